// File: rtl/cpu7_ifu_imem_if.sv
// cpu7 IFU instruction-memory interface: in-order fetch tag FIFO,
// redirect squash of in-flight reads, local ADEF for misaligned PCs.
module cpu7_ifu_imem_if #(
  parameter int          GRLEN           = 32,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [5:0]  EXCCODE_ADEF    = 6'h08,
  parameter logic [2:0]  UNCACHE_SEG     = 3'b101
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  input  logic             inst_cancel,
  output logic             inst_addr_ok,
  output logic             inst_valid_f,
  output logic [GRLEN-1:0] inst_rdata_f,
  output logic             inst_ex,
  output logic [5:0]       inst_exccode,
  output logic [1:0]       inst_count,
  output logic             inst_uncache,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_addr_ok,
  input  logic             imem_data_ok,
  input  logic [31:0]      imem_rdata
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  logic [1:0] cnt_q, cnt_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] unc_q, unc_d;
  logic [3:0] disc_q, disc_d;
  logic       adef_pend_q, adef_pend_d;

  logic aligned;
  logic push;
  logic pop;
  logic adef_acc;
  logic head_drop;
  logic deliver;
  logic adef_out;

  // Pointers wrap at the configured depth, not at the 2-bit limit.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == MAX_CNT - 2'd1) ? 2'd0 : p + 2'd1;
  endfunction

  // Request side: bus issue and local misaligned-fetch accept.
  always_comb begin
    aligned  = (inst_addr[1:0] == 2'b00);
    imem_req = inst_req & aligned & ~inst_cancel & ~reset &
               (cnt_q < MAX_CNT) & ~adef_pend_q;
    imem_addr = inst_addr;
    push      = imem_req & imem_addr_ok;
    adef_acc  = inst_req & ~aligned & ~inst_cancel & ~reset &
                ~adef_pend_q & (cnt_q == 2'd0);
    inst_addr_ok = push | adef_acc;
  end

  // Response side: pop the head, suppress squashed or redirected words.
  always_comb begin
    pop       = imem_data_ok & (cnt_q != 2'd0) & ~reset;
    head_drop = disc_q[rd_ptr_q] | inst_cancel;
    deliver   = pop & ~head_drop;
    adef_out  = adef_pend_q & ~inst_cancel & ~reset;
    inst_valid_f = 1'b0;
    inst_rdata_f = '0;
    inst_ex      = 1'b0;
    inst_exccode = 6'h00;
    inst_uncache = 1'b0;
    if (adef_out) begin
      inst_valid_f = 1'b1;
      inst_ex      = 1'b1;
      inst_exccode = EXCCODE_ADEF;
    end else if (deliver) begin
      inst_valid_f = 1'b1;
      inst_rdata_f = GRLEN'(imem_rdata);
      inst_uncache = unc_q[rd_ptr_q];
    end
    inst_count = {1'b0, inst_valid_f};
  end

  // Next-state for the tag FIFO and the one-shot ADEF flag.
  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    unc_d    = unc_q;
    disc_d   = disc_q;
    if (inst_cancel) begin
      disc_d = 4'hf;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      unc_d[wr_ptr_q]  = (inst_addr[31:29] == UNCACHE_SEG);
      disc_d[wr_ptr_q] = 1'b0;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
    adef_pend_d = adef_acc;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      unc_q       <= 4'h0;
      disc_q      <= 4'h0;
      adef_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      unc_q       <= unc_d;
      disc_q      <= disc_d;
      adef_pend_q <= adef_pend_d;
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_imem_if.sv
// Bench for cpu7_ifu_imem_if: queue-based reference model checked
// every cycle, directed scenarios with literal pins, random soak.
module tb_cpu7_ifu_imem_if;

  localparam int MAXO = 2;

  logic        clock;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_valid_f;
  logic [31:0] inst_rdata_f;
  logic        inst_ex;
  logic [5:0]  inst_exccode;
  logic [1:0]  inst_count;
  logic        inst_uncache;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_addr_ok;
  logic        imem_data_ok;
  logic [31:0] imem_rdata;

  cpu7_ifu_imem_if #(
    .GRLEN(32),
    .MAX_OUTSTANDING(MAXO),
    .EXCCODE_ADEF(6'h08),
    .UNCACHE_SEG(3'b101)
  ) dut (
    .clock(clock),
    .reset(reset),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok),
    .inst_valid_f(inst_valid_f),
    .inst_rdata_f(inst_rdata_f),
    .inst_ex(inst_ex),
    .inst_exccode(inst_exccode),
    .inst_count(inst_count),
    .inst_uncache(inst_uncache),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_addr_ok(imem_addr_ok),
    .imem_data_ok(imem_data_ok),
    .imem_rdata(imem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit unc;
    bit disc;
  } ent_t;

  ent_t q[$];
  bit   m_adef;
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model.
  task automatic model_step();
    bit       al, e_req, e_acc, e_adef, e_val, e_ex, e_unc;
    bit [31:0] e_rd;
    bit [5:0]  e_code;
    bit        popd;
    ent_t      ne;
    al = (inst_addr[1:0] == 2'b00);
    e_req = 0; e_acc = 0; e_adef = 0; e_val = 0; e_ex = 0;
    e_unc = 0; e_rd = 0; e_code = 0; popd = 0;
    if (!reset) begin
      e_req  = inst_req && al && !inst_cancel && q.size() < MAXO && !m_adef;
      e_adef = inst_req && !al && !inst_cancel && !m_adef && q.size() == 0;
      e_acc  = (e_req && imem_addr_ok) || e_adef;
      popd   = imem_data_ok && q.size() > 0;
      if (m_adef && !inst_cancel) begin
        e_val = 1; e_ex = 1; e_code = 6'h08;
      end else if (popd && !(q[0].disc || inst_cancel)) begin
        e_val = 1; e_rd = imem_rdata; e_unc = q[0].unc;
      end
    end
    chk("imem_req", 64'(imem_req), 64'(e_req));
    chk("imem_addr", 64'(imem_addr), 64'(inst_addr));
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(e_acc));
    chk("inst_valid_f", 64'(inst_valid_f), 64'(e_val));
    chk("inst_rdata_f", 64'(inst_rdata_f), 64'(e_rd));
    chk("inst_ex", 64'(inst_ex), 64'(e_ex));
    chk("inst_exccode", 64'(inst_exccode), 64'(e_code));
    chk("inst_uncache", 64'(inst_uncache), 64'(e_unc));
    chk("inst_count", 64'(inst_count), 64'(e_val ? 1 : 0));
    if (reset) begin
      q.delete();
      m_adef = 0;
    end else begin
      if (popd) void'(q.pop_front());
      if (inst_cancel) foreach (q[i]) q[i].disc = 1;
      if (e_req && imem_addr_ok) begin
        ne.unc  = (inst_addr[31:29] == 3'b101);
        ne.disc = 0;
        q.push_back(ne);
      end
      m_adef = e_adef;
    end
  endtask

  task automatic cyc(input bit rst, input bit req, input bit [31:0] addr,
                     input bit cnc, input bit aok, input bit dok,
                     input bit [31:0] rd);
    @(posedge clock);
    #1;
    reset = rst; inst_req = req; inst_addr = addr; inst_cancel = cnc;
    imem_addr_ok = aok; imem_data_ok = dok; imem_rdata = rd;
    @(negedge clock);
    model_step();
  endtask

  initial begin
    bit [31:0] r, a;
    bit [2:0]  seg;
    bit [1:0]  lo;
    clock = 0; reset = 1; inst_req = 0; inst_addr = 0; inst_cancel = 0;
    imem_addr_ok = 0; imem_data_ok = 0; imem_rdata = 0;
    checks = 0; failures = 0; m_adef = 0;

    cyc(1, 1, 32'h1c000000, 0, 1, 1, 32'hdead);
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_valid", 64'(inst_valid_f), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // basic
    cyc(0, 1, 32'h1c000000, 0, 1, 0, 0);
    chk("basic_aok0", 64'(inst_addr_ok), 1);
    cyc(0, 1, 32'h1c000004, 0, 1, 1, 32'haaaa0000);
    chk("basic_aok1", 64'(inst_addr_ok), 1);
    chk("basic_w0", 64'(inst_rdata_f), 64'h aaaa0000);
    chk("basic_cnt", 64'(inst_count), 1);
    cyc(0, 0, 0, 0, 0, 1, 32'haaaa0004);
    chk("basic_w1", 64'(inst_rdata_f), 64'haaaa0004);
    chk("basic_unc", 64'(inst_uncache), 0);

    // backpressure
    repeat (3) begin
      cyc(0, 1, 32'h1c000010, 0, 0, 0, 0);
      chk("bp_req", 64'(imem_req), 1);
      chk("bp_aok", 64'(inst_addr_ok), 0);
    end
    cyc(0, 1, 32'h1c000010, 0, 1, 0, 0);
    cyc(0, 1, 32'h1c000014, 0, 1, 0, 0);
    cyc(0, 1, 32'h1c000018, 0, 1, 0, 0);
    chk("bp_full", 64'(imem_req), 0);
    cyc(0, 1, 32'h1c000018, 0, 1, 1, 32'h10);
    chk("bp_full_pop", 64'(imem_req), 0);
    chk("bp_pop_val", 64'(inst_valid_f), 1);
    cyc(0, 1, 32'h1c000018, 0, 1, 0, 0);
    chk("bp_freed", 64'(imem_req), 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h14);
    cyc(0, 0, 0, 0, 0, 1, 32'h18);

    // cancel
    cyc(0, 1, 32'h1c000020, 0, 1, 0, 0);
    cyc(0, 1, 32'h1c000024, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 32'ha5);
    chk("cnc_same", 64'(inst_valid_f), 0);
    cyc(0, 0, 0, 0, 0, 1, 32'ha6);
    chk("cnc_next", 64'(inst_valid_f), 0);
    cyc(0, 1, 32'h1c000040, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h12345678);
    chk("cnc_fresh_v", 64'(inst_valid_f), 1);
    chk("cnc_fresh_d", 64'(inst_rdata_f), 64'h12345678);

    // misaligned
    cyc(0, 1, 32'h1c000002, 0, 1, 0, 0);
    chk("adef_noreq", 64'(imem_req), 0);
    chk("adef_aok", 64'(inst_addr_ok), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("adef_ex", 64'(inst_ex), 1);
    chk("adef_code", 64'(inst_exccode), 8);
    cyc(0, 1, 32'h1c000050, 0, 1, 0, 0);
    cyc(0, 1, 32'h1c000056, 0, 1, 0, 0);
    chk("adef_hold", 64'(inst_addr_ok), 0);
    cyc(0, 1, 32'h1c000056, 0, 1, 1, 32'h50);
    chk("adef_hold2", 64'(inst_addr_ok), 0);
    chk("adef_older", 64'(inst_rdata_f), 64'h50);
    cyc(0, 1, 32'h1c000056, 0, 1, 0, 0);
    chk("adef_acc2", 64'(inst_addr_ok), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("adef_ex2", 64'(inst_ex), 1);

    // uncache
    cyc(0, 1, 32'ha0000000, 0, 1, 0, 0);
    cyc(0, 1, 32'h1c000000, 0, 1, 1, 32'h77);
    chk("unc_1", 64'(inst_uncache), 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h78);
    chk("unc_0", 64'(inst_uncache), 0);
    chk("unc_0v", 64'(inst_valid_f), 1);

    // reset mid-flight
    cyc(0, 1, 32'h1c000060, 0, 1, 0, 0);
    cyc(0, 1, 32'h1c000064, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h99);
    chk("rst_mid", 64'(inst_valid_f), 0);
    cyc(0, 1, 32'h1c000068, 0, 1, 0, 0);
    chk("rst_after_aok", 64'(inst_addr_ok), 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h68);
    chk("rst_after_d", 64'(inst_rdata_f), 64'h68);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom();
      seg = ($urandom_range(0, 3) == 0) ? 3'b101 : 3'($urandom_range(0, 7));
      lo  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a   = {seg, r[28:2], lo};
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, a,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 1) == 1, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
